tag_pool: RTL

TAG_POOL -- requirements
Module: tag_pool

---
 rtl/tag_pool.sv | 72 +++++++
 1 files changed

// File: rtl/tag_pool.sv
// tag_pool: circular free list of physical register tags for a rename stage.
// Ports:
//   clk, rst           - single clock, synchronous active-high reset
//   PoolRetireEnable   - push PoolRetireTag back into the free list
//   PoolRetireTag      - tag being freed
//   AllocReq           - rename stage wants one tag
//   AllocValid         - head tag available; allocation fires on AllocReq & AllocValid
//   AllocTag           - current head of the free list
//   FreeCount          - number of tags currently in the free list
//   Ready              - initial fill of the list has completed
//   Error              - sticky flag for a dropped push (overflow or push while filling)
module tag_pool #(
    parameter int tag_w    = 6,
    parameter bit embedded = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PoolRetireEnable,
    input  logic [tag_w-1:0] PoolRetireTag,
    input  logic             AllocReq,
    output logic             AllocValid,
    output logic [tag_w-1:0] AllocTag,
    output logic [tag_w:0]   FreeCount,
    output logic             Ready,
    output logic             Error
);
    localparam int NARCH = embedded ? 16 : 32;
    localparam int DEPTH = 1 << tag_w;
    localparam logic [tag_w:0] CAP = (tag_w+1)'(DEPTH - NARCH);

    typedef enum logic {INIT, RUN} stateT;

    stateT            state;
    logic [tag_w-1:0] mem [DEPTH];
    logic [tag_w-1:0] rdPtr, wrPtr, initCnt, wrData;
    logic [tag_w:0]   count;
    logic             errReg, allocFire, pushOk, wrEn;

    assign AllocValid = (state == RUN) && (count != '0);
    assign AllocTag   = mem[rdPtr];
    assign FreeCount  = count;
    assign Ready      = (state == RUN);
    assign Error      = errReg;
    assign allocFire  = AllocReq && AllocValid;
    // A push into a full list is still legal when an allocation frees a slot the same cycle.
    assign pushOk     = (state == RUN) && PoolRetireEnable && ((count < CAP) || allocFire);
    assign wrEn       = (state == INIT) || pushOk;
    assign wrData     = (state == INIT) ? initCnt : PoolRetireTag;

    always_ff @(posedge clk)
        if (!rst && wrEn) mem[wrPtr] <= wrData;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= INIT;
            rdPtr   <= '0;
            wrPtr   <= '0;
            count   <= '0;
            initCnt <= tag_w'(NARCH);
            errReg  <= 1'b0;
        end else begin
            if (state == INIT) begin
                initCnt <= initCnt + 1'b1;
                if (&initCnt) state <= RUN;
            end
            if (wrEn) wrPtr <= wrPtr + 1'b1;
            if (allocFire) rdPtr <= rdPtr + 1'b1;
            count <= count + (tag_w+1)'(wrEn) - (tag_w+1)'(allocFire);
            if (PoolRetireEnable && !pushOk) errReg <= 1'b1;
        end
    end
endmodule
